// File: rtl/plot_pkg.sv
// Purpose : shared definitions for plot blocks: FSM state encoding, coordinate
//           width derivation and the screen clamp helper.
// Ports   : none (package).
package plot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAW  = 3'd2,
    ST_WAIT1 = 3'd3,
    ST_WAIT2 = 3'd4
  } plot_state_t;

  // Bits needed to address a screen axis of n pixels.
  function automatic int unsigned coord_width(input int unsigned n);
    return $clog2(n);
  endfunction

  // Saturate a signed value into [0, hi].
  function automatic longint clamp_range(input longint value, input longint hi);
    if (value < 0) return 0;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/plot_y_mapper.sv
// Purpose : maps a signed math-axis sample to a screen row: arithmetic shift,
//           flip around the screen centre, clamp to the visible rows.
// Ports   : sample (signed SAMPLE_WIDTH in), y (Y_WIDTH screen row out).
module plot_y_mapper
  import plot_pkg::*;
#(
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter int unsigned SAMPLE_WIDTH      = 16,
  parameter int unsigned Y_SHIFT           = 0,
  localparam int unsigned Y_WIDTH          = coord_width(VER_ACTIVE_PIXELS)
) (
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic        [Y_WIDTH-1:0]      y
);

  // Wide enough that centre minus any shifted sample cannot overflow.
  localparam int unsigned CALC_WIDTH = SAMPLE_WIDTH + Y_WIDTH + 1;

  logic signed [SAMPLE_WIDTH-1:0] shifted;
  logic signed [CALC_WIDTH-1:0]   shifted_ext;
  logic signed [CALC_WIDTH-1:0]   centre;
  logic signed [CALC_WIDTH-1:0]   diff;

  // Floor shift: >>> on a signed operand rounds toward minus infinity.
  assign shifted     = sample >>> Y_SHIFT;
  assign shifted_ext = CALC_WIDTH'(shifted);
  assign centre      = CALC_WIDTH'(VER_ACTIVE_PIXELS / 2);
  // Screen Y grows downward, so positive samples move up from the centre.
  assign diff        = centre - shifted_ext;
  assign y           = Y_WIDTH'(clamp_range(longint'(diff), longint'(VER_ACTIVE_PIXELS - 1)));

endmodule

// File: rtl/plot_sequencer.sv
// Purpose : walks the screen left to right, takes one Y sample per X column
//           step and issues consecutive polyline segments to the line drawer.
// Ports   : clk, rst (async, active-high)
//           start/ready/done          - plot control from top
//           sample/sample_valid/ready - sample stream from the evaluator
//           x1,y1,x2,y2, line_drawer_start/line_drawer_ready - drawer request
module plot_sequencer
  import plot_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter int unsigned SAMPLE_WIDTH      = 16,
  parameter int unsigned X_STEP            = 8,
  parameter int unsigned Y_SHIFT           = 0,
  localparam int unsigned X_WIDTH          = coord_width(HOR_ACTIVE_PIXELS),
  localparam int unsigned Y_WIDTH          = coord_width(VER_ACTIVE_PIXELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           ready,
  output logic                           done,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  output logic        [X_WIDTH-1:0]      x1,
  output logic        [Y_WIDTH-1:0]      y1,
  output logic        [X_WIDTH-1:0]      x2,
  output logic        [Y_WIDTH-1:0]      y2,
  output logic                           line_drawer_start,
  input  logic                           line_drawer_ready
);

  localparam int unsigned NUM_POINTS = HOR_ACTIVE_PIXELS / X_STEP;
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_POINTS) + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_POINTS - 1);

  if ((HOR_ACTIVE_PIXELS % X_STEP) != 0 || NUM_POINTS < 2) begin : g_bad_params
    $error("plot_sequencer: X_STEP must divide HOR_ACTIVE_PIXELS with at least 2 points");
  end

  plot_state_t          state;
  logic [IDX_WIDTH-1:0] idx;
  logic [X_WIDTH-1:0]   nx;
  logic [Y_WIDTH-1:0]   ny;

  plot_y_mapper #(
    .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
    .SAMPLE_WIDTH      (SAMPLE_WIDTH),
    .Y_SHIFT           (Y_SHIFT)
  ) u_y_mapper (
    .sample (sample),
    .y      (ny)
  );

  assign nx           = X_WIDTH'(int'(idx) * int'(X_STEP));
  assign ready        = (state == ST_IDLE);
  assign sample_ready = (state == ST_FETCH);

  // Sequencer FSM, point index and endpoint registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      idx               <= '0;
      x1                <= '0;
      y1                <= '0;
      x2                <= '0;
      y2                <= '0;
      line_drawer_start <= 1'b0;
      done              <= 1'b0;
    end else begin
      line_drawer_start <= 1'b0;
      done              <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (sample_valid) begin
            x1 <= x2;
            y1 <= y2;
            x2 <= nx;
            y2 <= ny;
            // The first point of a plot only seeds the polyline.
            if (idx == '0) idx <= IDX_WIDTH'(1);
            else           state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          line_drawer_start <= 1'b1;
          state             <= ST_WAIT1;
        end
        ST_WAIT1: begin
          // Drawer ready still reflects the pre-start idle level here.
          state <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (line_drawer_ready) begin
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              idx   <= '0;
              state <= ST_IDLE;
            end else begin
              idx   <= idx + IDX_WIDTH'(1);
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_sequencer.sv
// Purpose : directed self-checking bench for plot_sequencer; a Y_SHIFT=0 and a
//           Y_SHIFT=2 instance run in lockstep on the same stimulus.
// Ports   : none (top-level bench).
module tb_plot_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] sample = '0;
  logic               sample_valid = 1'b0;
  logic               line_drawer_ready;

  logic       ready, done, sample_ready, line_drawer_start;
  logic [9:0] x1, x2;
  logic [8:0] y1, y2;

  logic       b_ready, b_done, b_sample_ready, b_line_drawer_start;
  logic [9:0] b_x1, b_x2;
  logic [8:0] b_y1, b_y2;

  int total = 0;
  int bad   = 0;

  plot_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .ready             (ready),
    .done              (done),
    .sample            (sample),
    .sample_valid      (sample_valid),
    .sample_ready      (sample_ready),
    .x1                (x1),
    .y1                (y1),
    .x2                (x2),
    .y2                (y2),
    .line_drawer_start (line_drawer_start),
    .line_drawer_ready (line_drawer_ready)
  );

  plot_sequencer #(.Y_SHIFT(2)) dut2 (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .ready             (b_ready),
    .done              (b_done),
    .sample            (sample),
    .sample_valid      (sample_valid),
    .sample_ready      (b_sample_ready),
    .x1                (b_x1),
    .y1                (b_y1),
    .x2                (b_x2),
    .y2                (b_y2),
    .line_drawer_start (b_line_drawer_start),
    .line_drawer_ready (line_drawer_ready)
  );

  always #5 clk = ~clk;

  // Line drawer model: ready drops the cycle after a start for busy_len cycles.
  int busy_cnt = 0;
  int busy_len = 1;
  bit hold_low = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst)                    busy_cnt <= 0;
    else if (line_drawer_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0)      busy_cnt <= busy_cnt - 1;
  end

  assign line_drawer_ready = (busy_cnt == 0) && !hold_low;

  // Sample source: pops the queue on each valid&&ready transfer.
  logic signed [15:0] src_q[$];
  bit valid_block = 1'b0;

  always @(posedge clk) begin : src_blk
    bit xfer;
    xfer = sample_valid && sample_ready;
    #1;
    if (xfer && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0 && !valid_block) begin
      sample       = src_q[0];
      sample_valid = 1'b1;
    end else begin
      sample       = '0;
      sample_valid = 1'b0;
    end
  end

  // Segment log taken at each drawer start pulse.
  typedef struct {
    int x1; int y1; int x2; int y2; int by1; int by2;
  } seg_t;
  seg_t seg_q[$];
  int starts = 0;
  int dones  = 0;

  always @(posedge clk) begin
    if (line_drawer_start) begin
      seg_q.push_back('{int'(x1), int'(y1), int'(x2), int'(y2), int'(b_y1), int'(b_y2)});
      starts++;
    end
    if (done) dones++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (dones < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", int'(dones >= target), 1);
  endtask

  task automatic run_plot(input int head[$]);
    int base_d;
    seg_q.delete();
    foreach (head[i]) src_q.push_back(16'(head[i]));
    while (src_q.size() < 80) src_q.push_back('0);
    base_d = dones;
    pulse_start();
    wait_dones(base_d + 1);
    cycles(2);
  endtask

  initial begin
    int base_s;
    int base_d;
    int segbad;
    int vals[$];

    // Reset state
    cycles(1);
    check("rst_ready", int'(ready), 1);
    check("rst_sready", int'(sample_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_lds", int'(line_drawer_start), 0);
    check("rst_x1", int'(x1), 0);
    check("rst_y1", int'(y1), 0);
    check("rst_x2", int'(x2), 0);
    check("rst_y2", int'(y2), 0);
    rst = 1'b0;
    cycles(2);

    // All-zero plot: 79 horizontal segments on the centre row
    base_s = starts;
    base_d = dones;
    vals = '{};
    run_plot(vals);
    check("zero_starts", starts - base_s, 79);
    check("zero_done", dones - base_d, 1);
    check("zero_consumed", src_q.size(), 0);
    check("zero_segs", seg_q.size(), 79);
    segbad = 0;
    foreach (seg_q[k]) begin
      if (seg_q[k].x1 != k * 8 || seg_q[k].x2 != (k + 1) * 8 ||
          seg_q[k].y1 != 240 || seg_q[k].y2 != 240 || seg_q[k].by2 != 240)
        segbad++;
    end
    check("zero_seg_all", segbad, 0);
    if (seg_q.size() >= 79) begin
      check("zero_last_x1", seg_q[78].x1, 624);
      check("zero_last_x2", seg_q[78].x2, 632);
    end
    check("zero_idle", int'(ready), 1);

    // Clamp boundaries, plus floor shift on the Y_SHIFT=2 instance
    vals = '{300, -300, 240, -239, -240};
    run_plot(vals);
    check("clamp_segs", seg_q.size(), 79);
    if (seg_q.size() >= 4) begin
      check("clamp_y1_hi", seg_q[0].y1, 0);
      check("clamp_y2_lo", seg_q[0].y2, 479);
      check("clamp_exact0", seg_q[1].y2, 0);
      check("clamp_exact479", seg_q[2].y2, 479);
      check("clamp_over479", seg_q[3].y2, 479);
      check("clamp_vert_y1", seg_q[3].y1, 479);
      check("clamp_x2", seg_q[3].x2, 32);
      check("sh2_a", seg_q[0].by1, 165);
      check("sh2_b", seg_q[0].by2, 315);
      check("sh2_c", seg_q[1].by2, 180);
      check("sh2_d", seg_q[2].by2, 300);
      check("sh2_e", seg_q[3].by2, 300);
    end

    // Y_SHIFT=2 floor behaviour on small magnitudes
    vals = '{-40, 41, -41};
    run_plot(vals);
    if (seg_q.size() >= 2) begin
      check("sh2_neg40", seg_q[0].by1, 250);
      check("sh2_pos41", seg_q[0].by2, 230);
      check("sh2_neg41", seg_q[1].by2, 251);
      check("sh0_neg40", seg_q[0].y1, 280);
      check("sh0_pos41", seg_q[0].y2, 199);
      check("sh0_neg41", seg_q[1].y2, 281);
    end

    // Stalls: no sample, then drawer held busy, then valid withheld
    seg_q.delete();
    base_s = starts;
    base_d = dones;
    pulse_start();
    cycles(3);
    check("stall_sready", int'(sample_ready), 1);
    check("stall_nostart", starts - base_s, 0);
    hold_low = 1'b1;
    src_q.push_back(16'sd10);
    src_q.push_back(16'sd20);
    cycles(50);
    check("busy_starts", starts - base_s, 1);
    check("busy_sready", int'(sample_ready), 0);
    check("busy_ready", int'(ready), 0);
    check("busy_x1", int'(x1), 0);
    check("busy_y1", int'(y1), 230);
    check("busy_x2", int'(x2), 8);
    check("busy_y2", int'(y2), 220);
    valid_block = 1'b1;
    repeat (78) src_q.push_back('0);
    hold_low = 1'b0;
    cycles(10);
    check("vstall_sready", int'(sample_ready), 1);
    check("vstall_starts", starts - base_s, 1);
    check("vstall_x2", int'(x2), 8);
    check("vstall_y2", int'(y2), 220);
    check("vstall_queue", src_q.size(), 78);
    valid_block = 1'b0;
    wait_dones(base_d + 1);
    cycles(2);
    check("stall_total_starts", starts - base_s, 79);
    check("stall_total_done", dones - base_d, 1);

    // start held high through a whole plot and past done
    base_s = starts;
    base_d = dones;
    repeat (81) src_q.push_back('0);
    start = 1'b1;
    wait_dones(base_d + 1);
    cycles(4);
    check("hold_starts", starts - base_s, 79);
    check("hold_done", dones - base_d, 1);
    check("hold_consumed", src_q.size(), 0);
    check("hold_refetch", int'(sample_ready), 1);
    check("hold_x1", int'(x1), 632);
    check("hold_x2", int'(x2), 0);
    start = 1'b0;

    // Reset while waiting on the drawer
    hold_low = 1'b1;
    src_q.push_back(16'sd100);
    cycles(6);
    check("w2_ready", int'(ready), 0);
    check("w2_sready", int'(sample_ready), 0);
    check("w2_x2", int'(x2), 8);
    base_d = dones;
    #2 rst = 1'b1;
    #1;
    check("mrst_x1", int'(x1), 0);
    check("mrst_y1", int'(y1), 0);
    check("mrst_x2", int'(x2), 0);
    check("mrst_y2", int'(y2), 0);
    check("mrst_lds", int'(line_drawer_start), 0);
    @(negedge clk);
    rst = 1'b0;
    hold_low = 1'b0;
    @(negedge clk);
    check("post_ready", int'(ready), 1);
    check("post_sready", int'(sample_ready), 0);
    check("post_done", int'(done), 0);
    cycles(3);
    check("post_no_done", dones - base_d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
